// File: rtl/dma_ahb_pkg.sv
// Shared types and helpers for the DMA AHB channel arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dma_ahb_pkg;

    localparam int DMA_NCH_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    typedef logic [1:0] dma_prio_t;

    // Binary index of a one-hot vector; an all-zero vector maps to 0.
    function automatic logic [3:0] onehot_to_idx(input logic [DMA_NCH_MAX-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < DMA_NCH_MAX; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_ahb_rr_pick.sv
// Round-robin picker: first requester strictly after ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none; win_o is zero when no request is present.
module dma_ahb_rr_pick
    import dma_ahb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate back to ptr+1 so the nearest requester wins last.
    always_comb begin
        win_o = '0;
        cand  = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (req_i[cand]) begin
                win_o       = '0;
                win_o[cand] = 1'b1;
            end
        end
    end

    assign idx_o = IW'(onehot_to_idx(DMA_NCH_MAX'(win_o)));

endmodule

// File: rtl/dma_ahb_ch_arb.sv
// Channel arbiter for the DMA AHB master: round-robin whole-transfer grants with a beat quantum.
// Latency: grant registered 1 cycle after request; re-grant out of DRAIN has no idle gap.
// Backpressure: holds grant in DRAIN until eng_idle_i; DMA_ARB_PRIO_EN adds priority masking.
module dma_ahb_ch_arb
    import dma_ahb_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int QUANTUM = 16,
    localparam int CW      = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   ch_req_i,
`ifdef DMA_ARB_PRIO_EN
    input  logic [2*NCH-1:0] ch_prio_i,
`endif
    input  logic             eng_beat_i,
    input  logic             eng_idle_i,
    output logic [NCH-1:0]   grant_o,
    output logic [CW-1:0]    grant_idx_o,
    output logic             grant_vld_o,
    output logic [NCH-1:0]   preempt_o,
    output logic             busy_o
);

    // Counter must hold QUANTUM-1; with an unlimited quantum a 1-bit saturating count is enough.
    localparam int BW = (QUANTUM == 0) ? 1 : $clog2(QUANTUM + 1);

    arb_state_t     state_q;
    logic [NCH-1:0] grant_q;
    logic [CW-1:0]  grant_idx_q;
    logic           grant_vld_q;
    logic [NCH-1:0] preempt_q;
    logic [BW-1:0]  beat_cnt_q;
    logic [CW-1:0]  rr_ptr_q;

    logic [NCH-1:0] pick_req;
    logic [NCH-1:0] pick_win;
    logic [CW-1:0]  pick_idx;
    logic [CW-1:0]  pick_ptr;
    logic           req_drop;
    logic           quantum_hit;

`ifdef DMA_ARB_PRIO_EN
    dma_prio_t top_prio;

    // Keep only requesters sitting at the highest priority level currently asking.
    always_comb begin
        top_prio = '0;
        pick_req = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_req_i[i] && (ch_prio_i[2*i +: 2] > top_prio)) top_prio = ch_prio_i[2*i +: 2];
        end
        for (int i = 0; i < NCH; i++) begin
            pick_req[i] = ch_req_i[i] && (ch_prio_i[2*i +: 2] == top_prio);
        end
    end
`else
    assign pick_req = ch_req_i;
`endif

    // Leaving DRAIN the pointer moves to the released channel in the same cycle it re-arbitrates.
    assign pick_ptr = (state_q == DRAIN) ? grant_idx_q : rr_ptr_q;

    dma_ahb_rr_pick #(.N(NCH)) u_pick (
        .req_i (pick_req),
        .ptr_i (pick_ptr),
        .win_o (pick_win),
        .idx_o (pick_idx)
    );

    assign req_drop    = !ch_req_i[grant_idx_q];
    assign quantum_hit = (QUANTUM != 0) && eng_beat_i && (beat_cnt_q == BW'(QUANTUM - 1));

    // Grant state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            grant_vld_q <= 1'b0;
            preempt_q   <= '0;
            beat_cnt_q  <= '0;
            rr_ptr_q    <= CW'(NCH - 1);
        end else begin
            preempt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|ch_req_i) begin
                        grant_q     <= pick_win;
                        grant_idx_q <= pick_idx;
                        grant_vld_q <= 1'b1;
                        beat_cnt_q  <= '0;
                        state_q     <= OWN;
                    end
                end
                OWN: begin
                    if (eng_beat_i && (beat_cnt_q != '1)) beat_cnt_q <= beat_cnt_q + 1'b1;
                    if (req_drop || quantum_hit) state_q <= DRAIN;
                    // A channel that finishes on its last quantum beat is not told it was preempted.
                    if (quantum_hit && !req_drop) preempt_q <= grant_q;
                end
                DRAIN: begin
                    if (eng_idle_i) begin
                        rr_ptr_q <= grant_idx_q;
                        if (|ch_req_i) begin
                            grant_q     <= pick_win;
                            grant_idx_q <= pick_idx;
                            grant_vld_q <= 1'b1;
                            beat_cnt_q  <= '0;
                            state_q     <= OWN;
                        end else begin
                            grant_q     <= '0;
                            grant_idx_q <= '0;
                            grant_vld_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = grant_idx_q;
    assign grant_vld_o = grant_vld_q;
    assign preempt_o   = preempt_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dma_ahb_ch_arb.sv
// Self-checking bench for dma_ahb_ch_arb: vector table plus multi-cycle sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: engine idle/beat driven directly by the bench.
module tb_dma_ahb_ch_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       beat;
    logic       idle;
`ifdef DMA_ARB_PRIO_EN
    logic [7:0] prio;
`endif

    logic [3:0] g16, pre16, g4, pre4;
    logic [1:0] idx16, idx4;
    logic       vld16, busy16, vld4, busy4;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] req;
        logic       beat;
        logic       idle;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       vld;
        logic [3:0] pre;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       vld;
        logic [3:0] pre;
        logic       busy;
    } exp_t;

    vec_t vt[11];
    exp_t sb_q[$];
    int   ord_q[$];

    dma_ahb_ch_arb #(.NCH(4), .QUANTUM(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_req_i    (req),
`ifdef DMA_ARB_PRIO_EN
        .ch_prio_i   (prio),
`endif
        .eng_beat_i  (beat),
        .eng_idle_i  (idle),
        .grant_o     (g16),
        .grant_idx_o (idx16),
        .grant_vld_o (vld16),
        .preempt_o   (pre16),
        .busy_o      (busy16)
    );

    dma_ahb_ch_arb #(.NCH(4), .QUANTUM(4)) dut_q4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_req_i    (req),
`ifdef DMA_ARB_PRIO_EN
        .ch_prio_i   (prio),
`endif
        .eng_beat_i  (beat),
        .eng_idle_i  (idle),
        .grant_o     (g4),
        .grant_idx_o (idx4),
        .grant_vld_o (vld4),
        .preempt_o   (pre4),
        .busy_o      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        beat  = 1'b0;
        idle  = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Runs QUANTUM=4 instance with every grant expected to take exactly 4 counted beats.
    task automatic run_order(input string tag);
        int cur, beats, gaps, e;
        bit pre_seen, done;
        cur = -1; beats = 0; gaps = 0; pre_seen = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            step();
            if (cur >= 0 && !vld4) gaps++;
            if (vld4 && int'(idx4) != cur) begin
                if (cur >= 0) chk($sformatf("%s_beats_ch%0d", tag, cur), beats, 4);
                if (ord_q.size() > 0) begin
                    e = ord_q.pop_front();
                    chk($sformatf("%s_order", tag), {30'd0, idx4}, e);
                end
                cur = int'(idx4); beats = 0; pre_seen = 0;
            end
            if (pre4 != 0) begin
                chk($sformatf("%s_preempt_ch%0d", tag, cur), {28'd0, pre4}, 32'd1 << cur);
                pre_seen = 1;
                if (ord_q.size() == 0) begin
                    chk($sformatf("%s_beats_last", tag), beats, 4);
                    done = 1;
                end
            end else if (vld4 && !pre_seen) begin
                beats++;
            end
        end
        chk($sformatf("%s_completed", tag), {31'd0, done}, 1);
        chk($sformatf("%s_no_gap", tag), gaps, 0);
    endtask

    initial begin
        exp_t e;

        //      req      beat  idle  grant    idx   vld   pre   busy
        vt[0]  = '{4'b1010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0, 1'b1};
        vt[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0, 1'b1};
        vt[2]  = '{4'b0100, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0, 1'b1};
        vt[3]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0, 1'b1};
        vt[4]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0, 1'b1};
        vt[5]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0, 1'b1};
        vt[6]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0, 1'b1};
        vt[7]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0, 1'b1};
        vt[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0, 1'b1};
        vt[9]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0, 1'b0};
        vt[10] = '{4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b0, 1'b1};

`ifdef DMA_ARB_PRIO_EN
        prio = '0;
`endif
        rst_n = 1'b0; req = '0; beat = 1'b0; idle = 1'b1;
        step();
        chk("rst_grant",   {28'd0, g16},   0);
        chk("rst_idx",     {30'd0, idx16}, 0);
        chk("rst_vld",     {31'd0, vld16}, 0);
        chk("rst_preempt", {28'd0, pre16}, 0);
        chk("rst_busy",    {31'd0, busy16}, 0);
        chk("rst_q4_grant", {28'd0, g4}, 0);
        chk("rst_q4_busy",  {31'd0, busy4}, 0);

        // Table: first grant, drop in OWN, held DRAIN, gap-free regrant, release to IDLE.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            req = vt[i].req; beat = vt[i].beat; idle = vt[i].idle;
            sb_q.push_back('{grant: vt[i].grant, idx: vt[i].idx, vld: vt[i].vld,
                             pre: vt[i].pre, busy: vt[i].busy});
            step();
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_grant", i),   {28'd0, g16},    {28'd0, e.grant});
            chk($sformatf("vec%0d_idx", i),     {30'd0, idx16},  {30'd0, e.idx});
            chk($sformatf("vec%0d_vld", i),     {31'd0, vld16},  {31'd0, e.vld});
            chk($sformatf("vec%0d_preempt", i), {28'd0, pre16},  {28'd0, e.pre});
            chk($sformatf("vec%0d_busy", i),    {31'd0, busy16}, {31'd0, e.busy});
        end

        // Quantum expiry on ch1 after 16 beats, then gap-free handoff to ch3.
        do_reset();
        req = 4'b1010; idle = 1'b0;
        step();
        chk("q16_first_grant", {28'd0, g16}, 4'b0010);
        beat = 1'b1;
        repeat (15) step();
        chk("q16_no_pre_at15", {28'd0, pre16}, 0);
        chk("q16_grant_at15",  {28'd0, g16}, 4'b0010);
        step();
        chk("q16_pre_at16",    {28'd0, pre16}, 4'b0010);
        chk("q16_grant_held",  {28'd0, g16}, 4'b0010);
        beat = 1'b0; idle = 1'b1;
        step();
        chk("q16_handoff_grant", {28'd0, g16}, 4'b1000);
        chk("q16_handoff_vld",   {31'd0, vld16}, 1);
        chk("q16_pre_cleared",   {28'd0, pre16}, 0);

        // All channels requesting under QUANTUM=4: strict rotation, 4 beats each.
        do_reset();
        req = 4'b1111; beat = 1'b1; idle = 1'b1;
        ord_q = {0, 1, 2, 3, 0};
        run_order("rr4");

`ifdef DMA_ARB_PRIO_EN
        // ch1/ch2 at level 3 should share the engine, ch0/ch3 never win.
        do_reset();
        prio = {2'd1, 2'd3, 2'd3, 2'd0};
        req = 4'b1111; beat = 1'b1; idle = 1'b1;
        ord_q = {1, 2, 1, 2, 1, 2};
        run_order("prio");
        prio = '0;
`endif

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        req = 4'b0011; beat = 1'b0; idle = 1'b0;
        step();
        chk("arst_pre_grant", {28'd0, g16}, 4'b0001);
        beat = 1'b1;
        repeat (7) step();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_grant",   {28'd0, g16},    0);
        chk("arst_idx",     {30'd0, idx16},  0);
        chk("arst_vld",     {31'd0, vld16},  0);
        chk("arst_preempt", {28'd0, pre16},  0);
        chk("arst_busy",    {31'd0, busy16}, 0);
        req = 4'b0100; beat = 1'b0; idle = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_grant", {28'd0, g16},    4'b0100);
        chk("post_rst_idx",   {30'd0, idx16},  2);
        chk("post_rst_busy",  {31'd0, busy16}, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dma_ahb_ch_arb.md
Name: dma_ahb_ch_arb

Overview:
- Channel arbiter/scheduler for the single AHB master engine of the DMA.
- Shares the AHB master between NCH DMA channels with round-robin fairness and grants the engine for whole transfers.
- Enforces a per-grant beat quantum, so that one long channel cannot starve the others.
- Sits between the per-channel register/FSM blocks and the AHB master engine inside the DMA top level.

Parameters:
- NCH, 4, number of DMA channels (2..16).
- QUANTUM, 16, maximum data beats per grant before forced release; 0 = unlimited.
- CW, $clog2(NCH), channel index width (derived, not overridable).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_req_i  in  NCH  per-channel request; held high while the channel has beats to issue.
- ch_prio_i  in  2*NCH  per-channel priority, 3 = highest (present only with DMA_ARB_PRIO_EN).
- eng_beat_i  in  1  one AHB data beat completed for the granted channel (HREADY & data phase).
- eng_idle_i  in  1  engine has no outstanding address/data phase.
- grant_o  out  NCH  one-hot grant, registered.
- grant_idx_o  out  CW  binary index of grant_o.
- grant_vld_o  out  1  a grant is active.
- preempt_o  out  NCH  one-cycle pulse to the channel whose quantum expired.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: grant_o=0, grant_idx_o=0, grant_vld_o=0, preempt_o=0, busy_o=0, state=IDLE, beat_cnt=0.
- rr_ptr resets to NCH-1, so channel 0 wins first.
- States: IDLE, OWN, DRAIN.
- IDLE:
  - If |ch_req_i, the winner is the first requester scanning from rr_ptr+1 upward, with wrap.
  - Register grant_o, grant_idx_o, grant_vld_o=1, beat_cnt=0, and go to OWN.
  - Grant is visible 1 cycle after the request is sampled.
- OWN:
  - beat_cnt increments on eng_beat_i.
  - Go to DRAIN when ch_req_i[g]==0.
  - Also go to DRAIN when QUANTUM!=0, beat_cnt==QUANTUM-1 and eng_beat_i; in this case preempt_o[g] pulses in the next cycle.
  - If both conditions occur in the same cycle, go to DRAIN with no preempt pulse.
- DRAIN:
  - grant_o is held; the channel must issue no new address phases.
  - Beats still completing are not counted toward a new grant.
  - When eng_idle_i=1, set rr_ptr=g.
  - Then, if |ch_req_i, re-arbitrate in the same cycle: the new grant is registered directly and the state goes to OWN, with no grant-free cycle.
  - Otherwise clear the grant and go to IDLE.
  - The just-released channel gets lowest priority. If it is the sole requester it is re-granted with beat_cnt=0.
- beat_cnt width is $clog2(QUANTUM+1). With QUANTUM=0 it saturates and never triggers release.
- A request dropping on a non-granted channel has no effect.
- A request rising during OWN/DRAIN waits for the next arbitration.
- grant_o is always one-hot or zero, and grant_vld_o==|grant_o.
- Reset asserted mid-transfer clears all state immediately (async). The first post-reset grant goes to the lowest-index requester.

Optional Feature:
- DMA_ARB_PRIO_EN defined:
  - ch_prio_i port exists.
  - Arbitration first masks requesters to the highest priority level present, then applies round-robin from rr_ptr+1 within that level.
  - Priority is sampled at arbitration only; a change during OWN does not preempt.
- Not defined:
  - ch_prio_i is absent.
  - Pure round-robin.

Decomposition:
- dma_ahb_pkg holds:
  - arb_state_t enum {IDLE, OWN, DRAIN};
  - DMA_NCH_MAX=16;
  - dma_prio_t (logic [1:0]);
  - function onehot_to_idx.
- One combinational sub-module, dma_ahb_rr_pick: parameter N; inputs req[N], ptr; outputs onehot win and idx.
  - Instantiated once, fed by a prio-masked request vector when DMA_ARB_PRIO_EN is defined.

Test Plan:
- Reset, then ch_req_i=4'b1010 → grant_o=4'b0010 one cycle later, grant_idx_o=1, busy_o=1.
- Ch1 granted, 16 eng_beat_i with req held → preempt_o[1] pulse, DRAIN; with eng_idle_i=1, grant_o becomes 4'b1000 with no gap.
- Ch2 granted, drops req after 3 beats, eng_idle_i low for 2 cycles → grant held 2 cycles, then grant_o=0, IDLE.
- All 4 requesting continuously with QUANTUM=4 → grant order 0,1,2,3,0, each exactly 4 beats.
- DMA_ARB_PRIO_EN, prio={ch3:1, ch2:3, ch1:3, ch0:0}, all requesting → grants alternate ch1/ch2 only; ch0/ch3 are never granted while ch1/ch2 request.
- rst_n low during OWN with beat_cnt=7 → all outputs 0 asynchronously; after release with req=4'b0100, ch2 is granted.
